fetch_unit_if: RTL and testbench

- Instruction fetch stage for the RV32E 5-stage pipeline; the producer end of the IF/ID interface.
- Issues in-order word requests to instruction memory and buffers the returned words in a small FIFO tagged with their PCs.
- Presents pc0_IF, pc4_IF, instruction_IF and invalid_IF to the IF/ID pipeline register, and honours stall and redirect.

---
 rtl/fetch_unit_if.sv | 147 ++++++++++++++
 tb/tb_fetch_unit_if.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction fetch stage, producer side of the IF/ID interface.
//
// Issues in-order word requests to instruction memory, tags each returned word
// with its PC in a small FIFO, and presents the FIFO head to the IF/ID register.
// A redirect clears the FIFO and restarts fetch. Responses to requests issued
// before a redirect are discarded by counting them down in drop_count.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   stall                           IF/ID not capturing; hold the head entry
//   redirect_valid, redirect_pc     restart fetch at redirect_pc
//   imem_req, imem_addr, imem_ready request channel (accept = req && ready)
//   imem_rvalid, imem_rdata         in-order response channel
//   pc0_IF, pc4_IF, instruction_IF  presented slot
//   invalid_IF                      presented slot is a bubble (nop 0x13)
//   fetch_fault                     only with FETCH_MISALIGN_CHECK_EN defined:
//                                   set by a redirect to a misaligned PC
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When undefined, the low
// two bits of redirect_pc are ignored.

module fetch_unit_if #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc0_IF,
  output logic [31:0] pc4_IF,
  output logic [31:0] instruction_IF,
  output logic        invalid_IF
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   word_mem [FIFO_DEPTH];

  logic [CW+1:0] credit_used;
  logic [31:0]   redirect_tgt;
  logic          fault_block;
  logic          accept;
  logic          resp_keep;
  logic          resp_drop;
  logic          push;
  logic          pop;
  logic          head_valid;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fault_block = fetch_fault;
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign fault_block = 1'b0;
`endif

  // Words dropped after a redirect still occupy credit until they return, so
  // the sum of all three counters never exceeds FIFO_DEPTH.
  assign credit_used = (CW+2)'(count) + (CW+2)'(outstanding) + (CW+2)'(drop_count);

  assign imem_req  = rst_n && !redirect_valid && !fault_block &&
                     (credit_used < (CW+2)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;

  assign resp_keep = imem_rvalid && (drop_count == '0);
  assign resp_drop = imem_rvalid && (drop_count != '0);
  assign push      = resp_keep && !redirect_valid;

  assign head_valid     = (count != '0);
  assign invalid_IF     = !head_valid || redirect_valid;
  assign pop            = !stall && !invalid_IF;
  assign pc0_IF         = head_valid ? pc_mem[rd_ptr] : 32'h0;
  assign pc4_IF         = head_valid ? pc_mem[rd_ptr] + 32'd4 : 32'h0;
  assign instruction_IF = invalid_IF ? 32'h0000_0013 : word_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fetch_fault <= 1'b0;
`endif
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_tgt;
      resp_pc     <= redirect_tgt;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= '0;
      // A response landing in the redirect cycle belongs to the old stream,
      // so it retires one of the words that would otherwise need dropping.
      drop_count  <= drop_count + outstanding - CW'(imem_rvalid);
`ifdef FETCH_MISALIGN_CHECK_EN
      fetch_fault <= |redirect_pc[1:0];
`endif
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(accept) - CW'(resp_keep);
      if (resp_drop) drop_count <= drop_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      word_mem[wr_ptr] <= imem_rdata;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_unit_if.sv
module tb_fetch_unit_if;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc0_IF, pc4_IF, instruction_IF;
  logic        invalid_IF;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  always #5 clk = ~clk;

  fetch_unit_if #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc0_IF(pc0_IF), .pc4_IF(pc4_IF), .instruction_IF(instruction_IF),
    .invalid_IF(invalid_IF)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] q[$];
  logic        mem_hold = 1'b0;
  logic [31:0] exp_pc;
  int          pops;
  logic        saw_zero_req;
  logic        saw_wrap_pop;

  typedef struct {
    logic        stall;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_inv;
    logic [31:0] exp_pc0;
    logic [31:0] exp_ins;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory model: returns words in order, one cycle or more after acceptance.
  task automatic settle();
    imem_rvalid = (q.size() > 0) && !mem_hold;
    if (imem_rvalid) imem_rdata = q[0] ^ KEY;
    else imem_rdata = 32'h0;
    #1;
  endtask

  task automatic advance();
    if (imem_rvalid) q.delete(0);
    if (imem_req && imem_ready) q.push_back(imem_addr);
    @(negedge clk);
  endtask

  // Presentation model: popped entries must follow exp_pc in order.
  task automatic observe();
    settle();
    if (imem_req && imem_addr == 32'h0) saw_zero_req = 1'b1;
    if (!invalid_IF && !stall) begin
      chk("pop_pc0", pc0_IF, exp_pc);
      chk("pop_pc4", pc4_IF, exp_pc + 32'd4);
      chk("pop_instr", instruction_IF, exp_pc ^ KEY);
      if (exp_pc == 32'hFFFF_FFFC) saw_wrap_pop = 1'b1;
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      observe();
      advance();
    end
  endtask

  task automatic do_redirect(input logic [31:0] tgt, input logic hold);
    mem_hold = hold;
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    settle();
    chk("redir_invalid", 32'(invalid_IF), 32'd1);
    chk("redir_instr", instruction_IF, NOP);
    chk("redir_req", 32'(imem_req), 32'd0);
    advance();
    redirect_valid = 1'b0;
    mem_hold = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h0,   NOP};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h104, 1'b1, 32'h0,   NOP};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h108, 1'b0, 32'h100, 32'hA5A5_0100};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h108, 1'b0, 32'h104, 32'hA5A5_0104};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h0,   NOP};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h110, 1'b0, 32'h108, 32'hA5A5_0108};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h110, 1'b0, 32'h108, 32'hA5A5_0108};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h110, 1'b0, 32'h108, 32'hA5A5_0108};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h110, 1'b0, 32'h108, 32'hA5A5_0108};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h110, 1'b0, 32'h108, 32'hA5A5_0108};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h110, 1'b0, 32'h108, 32'hA5A5_0108};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h110, 1'b0, 32'h10C, 32'hA5A5_010C};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h114, 1'b1, 32'h0,   NOP};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 32'h118, 1'b0, 32'h110, 32'hA5A5_0110};

    pops = 0;
    saw_zero_req = 1'b0;
    saw_wrap_pop = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    settle();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_invalid", 32'(invalid_IF), 32'd1);
    chk("rst_instr", instruction_IF, NOP);
    chk("rst_pc0", pc0_IF, 32'h0);
    chk("rst_pc4", pc4_IF, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_fault", 32'(fetch_fault), 32'd0);
`endif
    rst_n = 1'b1;

    // Start-up fetch stream, then a 5-cycle stall with the FIFO full
    for (int i = 0; i < 14; i++) begin
      stall = tbl[i].stall;
      imem_ready = tbl[i].ready;
      settle();
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("v%0d_invalid", i), 32'(invalid_IF), 32'(tbl[i].exp_inv));
      chk($sformatf("v%0d_pc0", i), pc0_IF, tbl[i].exp_pc0);
      chk($sformatf("v%0d_pc4", i), pc4_IF,
          (tbl[i].exp_pc0 == 32'h0) ? 32'h0 : tbl[i].exp_pc0 + 32'd4);
      chk($sformatf("v%0d_instr", i), instruction_IF, tbl[i].exp_ins);
      advance();
    end
    stall = 1'b0;
    exp_pc = 32'h114;

    // Memory not ready: address held, request held, FIFO drains to bubbles
    imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      observe();
      chk("nrdy_req", 32'(imem_req), 32'd1);
      chk("nrdy_addr", imem_addr, 32'h118);
      if (k == 2) begin
        chk("nrdy_invalid", 32'(invalid_IF), 32'd1);
        chk("nrdy_instr", instruction_IF, NOP);
      end
      advance();
    end
    imem_ready = 1'b1;
    pops = 0;
    run(8);
    chk("resume_pops", 32'(pops >= 3), 32'd1);

    // Redirect with two requests outstanding
    mem_hold = 1'b1;
    run(4);
    chk("outstanding_before_redirect", 32'(q.size()), 32'd2);
    do_redirect(32'h0000_2000, 1'b1);
    exp_pc = 32'h0000_2000;
    pops = 0;
    run(10);
    chk("redir_progress", 32'(pops >= 2), 32'd1);

    // Back-to-back redirects; a late response lands in the second one
    mem_hold = 1'b1;
    run(4);
    do_redirect(32'h0000_4000, 1'b1);
    do_redirect(32'h0000_5000, 1'b0);
    exp_pc = 32'h0000_5000;
    pops = 0;
    run(10);
    chk("b2b_progress", 32'(pops >= 2), 32'd1);

    // Address wrap at 2^32
    mem_hold = 1'b1;
    run(4);
    do_redirect(32'hFFFF_FFF8, 1'b1);
    exp_pc = 32'hFFFF_FFF8;
    saw_zero_req = 1'b0;
    saw_wrap_pop = 1'b0;
    run(12);
    chk("wrap_req_zero", 32'(saw_zero_req), 32'd1);
    chk("wrap_pop_seen", 32'(saw_wrap_pop), 32'd1);

    // Misaligned redirect
    mem_hold = 1'b1;
    run(4);
`ifdef FETCH_MISALIGN_CHECK_EN
    do_redirect(32'h0000_3002, 1'b1);
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("fault_set", 32'(fetch_fault), 32'd1);
      chk("fault_req", 32'(imem_req), 32'd0);
      chk("fault_invalid", 32'(invalid_IF), 32'd1);
      advance();
    end
    do_redirect(32'h0000_3000, 1'b1);
    exp_pc = 32'h0000_3000;
    settle();
    chk("fault_clear", 32'(fetch_fault), 32'd0);
    pops = 0;
    run(10);
    chk("fault_resume", 32'(pops >= 2), 32'd1);
`else
    do_redirect(32'h0000_3002, 1'b1);
    exp_pc = 32'h0000_3000;
    pops = 0;
    run(10);
    chk("misalign_forced", 32'(pops >= 2), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
